// File: rtl/wb_trace_checker.sv
// Writeback snooper: shadows the regfile and traces writes for CYCLE_LIMIT cycles, then sweeps NREG entries against an expected table.
// Trace FIFO head is combinational; a full FIFO drops writebacks (sticky trace_ovf). Define MISMATCH_LOG_EN to latch the first mismatch.
module wb_trace_checker #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int DEPTH       = 16,
   parameter int CYCLE_W     = 32,
   parameter int CYCLE_LIMIT = 1000,
   parameter int ERR_W       = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic               wb_we,
   input  logic [REG_AW-1:0]  wb_reg,
   input  logic [DATA_W-1:0]  wb_data,
   input  logic               exp_we,
   input  logic [REG_AW-1:0]  exp_reg,
   input  logic [DATA_W-1:0]  exp_data,
   input  logic               exp_clr,
   output logic               trace_valid,
   input  logic               trace_rd,
   output logic [CYCLE_W-1:0] trace_cycle,
   output logic [REG_AW-1:0]  trace_reg,
   output logic [DATA_W-1:0]  trace_data,
   output logic               trace_ovf,
   output logic               busy,
   output logic               done,
   output logic [CYCLE_W-1:0] cycle_count,
   output logic [ERR_W-1:0]   error_count,
   output logic [REG_AW-1:0]  first_err_reg,
   output logic [DATA_W-1:0]  first_err_read,
   output logic [DATA_W-1:0]  first_err_exp
);

   localparam int NREG  = 2**REG_AW;
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

   typedef struct packed {
      logic [CYCLE_W-1:0] cyc;
      logic [REG_AW-1:0]  rg;
      logic [DATA_W-1:0]  dat;
   } trace_t;

   state_t              state_q, state_d;
   logic                run_entry, run_last, check_last, in_check;
   logic [REG_AW-1:0]   check_idx;
   logic [DATA_W-1:0]   shadow [NREG];
   logic [NREG-1:0]     shadow_valid;
   logic [DATA_W-1:0]   exp_mem [NREG];
   logic [NREG-1:0]     exp_valid, exp_valid_nxt;
   logic                exp_ok, wb_hit;
   logic [DATA_W-1:0]   chk_read;
   logic                mismatch;
   trace_t              fifo_mem [DEPTH];
   trace_t              push_ent, head_ent;
   logic [PTR_W:0]      wr_ptr, rd_ptr;
   logic                fifo_empty, fifo_full, push, pop;

   assign run_last   = (cycle_count == CYCLE_W'(CYCLE_LIMIT - 1));
   assign check_last = &check_idx;
   assign in_check   = (state_q == S_CHECK) && !abort;
   assign exp_ok     = (state_q == S_IDLE) || (state_q == S_DONE);
   assign wb_hit     = (state_q == S_RUN) && wb_we && (wb_reg != '0);

   always_comb begin
      state_d   = state_q;
      run_entry = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: if (start) begin
               state_d   = S_RUN;
               run_entry = 1'b1;
            end
            S_RUN:   if (run_last) state_d = S_CHECK;
            S_CHECK: if (check_last) state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   assign busy = (state_q == S_RUN) || (state_q == S_CHECK);
   assign done = (state_q == S_DONE);

   // Unwritten registers read back as zero during the sweep.
   assign chk_read = shadow_valid[check_idx] ? shadow[check_idx] : '0;
   assign mismatch = exp_valid[check_idx] && (chk_read != exp_mem[check_idx]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycle_count <= '0;
         error_count <= '0;
         check_idx   <= '0;
      end else if (run_entry) begin
         cycle_count <= '0;
         error_count <= '0;
         check_idx   <= '0;
      end else begin
         if ((state_q == S_RUN) && !abort) cycle_count <= cycle_count + 1'b1;
         if (in_check) begin
            check_idx <= check_idx + 1'b1;
            if (mismatch && (error_count != '1)) error_count <= error_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)         shadow_valid <= '0;
      else if (run_entry) shadow_valid <= '0;
      else if (wb_hit)    shadow_valid[wb_reg] <= 1'b1;
   end

   always_ff @(posedge clock) begin
      if (wb_hit) shadow[wb_reg] <= wb_data;
   end

   // Clear applies first so a same-cycle write survives it.
   always_comb begin
      exp_valid_nxt = exp_valid;
      if (exp_clr) exp_valid_nxt = '0;
      if (exp_we)  exp_valid_nxt[exp_reg] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)      exp_valid <= '0;
      else if (exp_ok) exp_valid <= exp_valid_nxt;
   end

   always_ff @(posedge clock) begin
      if (exp_ok && exp_we) exp_mem[exp_reg] <= exp_data;
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop        = trace_rd && !fifo_empty;
   assign push       = wb_hit && (!fifo_full || pop);
   assign push_ent   = {cycle_count, wb_reg, wb_data};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         trace_ovf <= 1'b0;
      end else if (run_entry) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         trace_ovf <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (wb_hit && fifo_full && !pop) trace_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= push_ent;
   end

   // Head is gated so the trace outputs read zero whenever the FIFO is empty.
   assign head_ent    = fifo_mem[rd_ptr[PTR_W-1:0]];
   assign trace_valid = !fifo_empty;
   assign trace_cycle = trace_valid ? head_ent.cyc : '0;
   assign trace_reg   = trace_valid ? head_ent.rg  : '0;
   assign trace_data  = trace_valid ? head_ent.dat : '0;

`ifdef MISMATCH_LOG_EN
   // error_count is zero only until the first mismatch of the current sweep.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         first_err_reg  <= '0;
         first_err_read <= '0;
         first_err_exp  <= '0;
      end else if (run_entry) begin
         first_err_reg  <= '0;
         first_err_read <= '0;
         first_err_exp  <= '0;
      end else if (in_check && mismatch && (error_count == '0)) begin
         first_err_reg  <= check_idx;
         first_err_read <= chk_read;
         first_err_exp  <= exp_mem[check_idx];
      end
   end
`else
   assign first_err_reg  = '0;
   assign first_err_read = '0;
   assign first_err_exp  = '0;
`endif

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker with CYCLE_LIMIT=8, DEPTH=4, NREG=32.
module tb_wb_trace_checker;

   logic        clock = 1'b0;
   logic        reset, start, abort, wb_we, exp_we, exp_clr, trace_rd;
   logic [4:0]  wb_reg, exp_reg;
   logic [31:0] wb_data, exp_data;
   logic        trace_valid, trace_ovf, busy, done;
   logic [31:0] trace_cycle, trace_data, cycle_count, first_err_read, first_err_exp;
   logic [4:0]  trace_reg, first_err_reg;
   logic [15:0] error_count;

   int checks = 0;
   int errors = 0;
   int n      = 0;

`ifdef MISMATCH_LOG_EN
   localparam logic [4:0]  FE_REG = 5'd3;
   localparam logic [31:0] FE_EXP = 32'd9;
`else
   localparam logic [4:0]  FE_REG = 5'd0;
   localparam logic [31:0] FE_EXP = 32'd0;
`endif

   always #5 clock = ~clock;

   wb_trace_checker #(
      .DATA_W(32), .REG_AW(5), .DEPTH(4), .CYCLE_W(32), .CYCLE_LIMIT(8), .ERR_W(16)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
      .exp_we(exp_we), .exp_reg(exp_reg), .exp_data(exp_data), .exp_clr(exp_clr),
      .trace_valid(trace_valid), .trace_rd(trace_rd), .trace_cycle(trace_cycle),
      .trace_reg(trace_reg), .trace_data(trace_data), .trace_ovf(trace_ovf),
      .busy(busy), .done(done), .cycle_count(cycle_count), .error_count(error_count),
      .first_err_reg(first_err_reg), .first_err_read(first_err_read), .first_err_exp(first_err_exp)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      n++;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
   endtask

   task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
      wb_we   = we;
      wb_reg  = r;
      wb_data = d;
   endtask

   task automatic pop();
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         tick();
         k++;
      end
      chk("done_reached", done, 1);
   endtask

   task automatic chk_head(input string tag, input logic [31:0] c, input logic [4:0] r,
                           input logic [31:0] d);
      chk({tag, "_valid"}, trace_valid, 1);
      chk({tag, "_cycle"}, trace_cycle, c);
      chk({tag, "_reg"},   trace_reg,   r);
      chk({tag, "_data"},  trace_data,  d);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; trace_rd = 1'b0;
      exp_we = 1'b0; exp_clr = 1'b0; exp_reg = '0; exp_data = '0;
      wb(1'b0, 5'd0, 32'd0);
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cycle", cycle_count, 0);
      chk("rst_err", error_count, 0);
      chk("rst_tvalid", trace_valid, 0);
      chk("rst_ovf", trace_ovf, 0);
      #10 reset = 1'b1;
      tick();

      // Run 1: r1=5@c1, r2=7@c3 against exp r1=5, r2=7; exp write during RUN is ignored.
      exp_we = 1'b1; exp_reg = 5'd1; exp_data = 32'd5; tick();
      exp_reg = 5'd2; exp_data = 32'd7; tick();
      exp_we = 1'b0;
      do_start();
      chk("run1_busy", busy, 1);
      chk("run1_cycle0", cycle_count, 0);
      tick();
      wb(1'b1, 5'd1, 32'd5);
      exp_we = 1'b1; exp_reg = 5'd1; exp_data = 32'h99;
      tick();
      wb(1'b0, 5'd0, 32'd0);
      exp_we = 1'b0;
      tick();
      wb(1'b1, 5'd2, 32'd7);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      wait_done(100);
      chk("run1_latency", n, 40);
      chk("run1_cycles", cycle_count, 8);
      chk("run1_err", error_count, 0);
      chk("run1_ovf", trace_ovf, 0);
      chk("run1_fe_reg", first_err_reg, 0);
      chk_head("run1_e0", 32'd1, 5'd1, 32'd5);
      pop();
      chk_head("run1_e1", 32'd3, 5'd2, 32'd7);
      pop();
      chk("run1_empty", trace_valid, 0);

      // Run 2: clear+write same cycle leaves only r3=9; r0 write ignored so exp r0=0 passes.
      exp_clr = 1'b1; exp_we = 1'b1; exp_reg = 5'd3; exp_data = 32'd9; tick();
      exp_clr = 1'b0; exp_reg = 5'd0; exp_data = 32'd0; tick();
      exp_we = 1'b0;
      do_start();
      wb(1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      chk("run2_r0_notrace", trace_valid, 0);
      wait_done(100);
      chk("run2_err", error_count, 1);
      chk("run2_fe_reg", first_err_reg, FE_REG);
      chk("run2_fe_read", first_err_read, 0);
      chk("run2_fe_exp", first_err_exp, FE_EXP);

      // Run 3: six writes into a 4-deep FIFO, oldest four kept.
      do_start();
      chk("run3_fe_clr", first_err_reg, 0);
      for (int i = 0; i < 6; i++) begin
         wb(1'b1, 5'(i + 1), 32'h10 + 32'(i));
         tick();
      end
      wb(1'b0, 5'd0, 32'd0);
      chk("run3_ovf", trace_ovf, 1);
      for (int j = 0; j < 4; j++) begin
         chk_head("run3_e", 32'(j), 5'(j + 1), 32'h10 + 32'(j));
         pop();
      end
      chk("run3_empty", trace_valid, 0);
      wait_done(100);

      // Run 4: push with simultaneous pop while full is accepted.
      do_start();
      chk("run4_ovf_clr", trace_ovf, 0);
      for (int i = 0; i < 4; i++) begin
         wb(1'b1, 5'(i + 1), 32'h20 + 32'(i));
         tick();
      end
      wb(1'b1, 5'd5, 32'h24);
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
      wb(1'b0, 5'd0, 32'd0);
      chk("run4_ovf", trace_ovf, 0);
      for (int j = 0; j < 4; j++) begin
         chk_head("run4_e", 32'(j + 1), 5'(j + 2), 32'h21 + 32'(j));
         pop();
      end
      chk("run4_empty", trace_valid, 0);
      wait_done(100);

      // Abort at RUN cycle 3, abort beats start, then restart from zero.
      do_start();
      tick(); tick(); tick();
      chk("abort_cycle3", cycle_count, 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      chk("abort_wins", busy, 0);
      do_start();
      chk("restart_busy", busy, 1);
      chk("restart_cycle", cycle_count, 0);

      // Reset during CHECK clears everything asynchronously, including the exp table.
      tick();
      wb(1'b1, 5'd5, 32'hAB);
      tick();
      wb(1'b0, 5'd0, 32'd0);
      repeat (11) tick();
      chk("pre_rst_busy", busy, 1);
      chk("pre_rst_err", error_count, 1);
      chk("pre_rst_tvalid", trace_valid, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_cycle", cycle_count, 0);
      chk("arst_err", error_count, 0);
      chk("arst_tvalid", trace_valid, 0);
      chk("arst_tdata", trace_data, 0);
      chk("arst_fe_reg", first_err_reg, 0);
      tick();
      reset = 1'b1;
      do_start();
      wait_done(100);
      chk("post_rst_err", error_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
